// File: rtl/adc_pattern_pkg.sv
// Shared types and constants for the ADC test-pattern generator.
// Holds the waveform mode encoding, LFSR parameters and a rotate helper.
package adc_pattern_pkg;

  typedef enum logic [1:0] {PAT_RAMP, PAT_TRI, PAT_CONST, PAT_NOISE} pat_mode_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Rotate a 16-bit word left so each channel sees a decorrelated view of the shared LFSR.
  function automatic logic [15:0] rotl16(input logic [15:0] x, input int unsigned n);
    logic [31:0] t;
    t = {x, x} << (n % 16);
    return t[31:16];
  endfunction

endpackage

// File: rtl/adc_pattern_ch.sv
// One pattern channel: shadow configuration, triangle direction flag and
// next-sample arithmetic, computed two bits wider than the sample so nothing wraps.
module adc_pattern_ch
  import adc_pattern_pkg::*;
#(
  parameter int DW = 14
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          run_i,
  input  logic [1:0]    mode_i,
  input  logic [DW-1:0] lo_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] step_i,
  input  logic [DW-1:0] start_i,
  input  logic [DW-1:0] noise_i,
  output logic [DW-1:0] dat_o
);

  localparam int EW = DW + 2;

  pat_mode_t     r_mode;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_step;
  logic [DW-1:0] r_start;
  logic [DW-1:0] r_dat;
  logic          r_dir_down;

  logic signed [EW-1:0] w_dat_x;
  logic signed [EW-1:0] w_lo_x;
  logic signed [EW-1:0] w_hi_x;
  logic signed [EW-1:0] w_step_x;
  logic signed [EW-1:0] w_noise_x;
  logic signed [EW-1:0] w_sum_x;
  logic signed [EW-1:0] w_diff_x;
  logic [DW-1:0]        w_dat_next;
  logic                 w_dir_next;

  assign w_dat_x   = {{2{r_dat[DW-1]}}, r_dat};
  assign w_lo_x    = {{2{r_lo[DW-1]}}, r_lo};
  assign w_hi_x    = {{2{r_hi[DW-1]}}, r_hi};
  assign w_step_x  = {2'b00, r_step};
  assign w_noise_x = {{2{noise_i[DW-1]}}, noise_i};
  assign w_sum_x   = w_dat_x + w_step_x;
  assign w_diff_x  = w_dat_x - w_step_x;

  always_comb begin
    w_dat_next = r_dat;
    w_dir_next = r_dir_down;
    if (w_lo_x > w_hi_x) begin
      w_dat_next = r_lo;
    end else begin
      case (r_mode)
        PAT_RAMP: begin
          if (w_dat_x >= w_hi_x)     w_dat_next = r_lo;
          else if (w_sum_x > w_hi_x) w_dat_next = r_hi;
          else                       w_dat_next = w_sum_x[DW-1:0];
        end
        PAT_TRI: begin
          if (!r_dir_down) begin
            if (w_sum_x >= w_hi_x) begin
              w_dat_next = r_hi;
              w_dir_next = 1'b1;
            end else begin
              w_dat_next = w_sum_x[DW-1:0];
            end
          end else begin
            if (w_diff_x <= w_lo_x) begin
              w_dat_next = r_lo;
              w_dir_next = 1'b0;
            end else begin
              w_dat_next = w_diff_x[DW-1:0];
            end
          end
        end
        PAT_CONST: w_dat_next = r_start;
        default: begin
          if (w_noise_x < w_lo_x)      w_dat_next = r_lo;
          else if (w_noise_x > w_hi_x) w_dat_next = r_hi;
          else                         w_dat_next = noise_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode     <= PAT_RAMP;
      r_lo       <= '0;
      r_hi       <= '0;
      r_step     <= '0;
      r_start    <= '0;
      r_dat      <= '0;
      r_dir_down <= 1'b0;
    end else if (load_i) begin
      r_mode     <= pat_mode_t'(mode_i);
      r_lo       <= lo_i;
      r_hi       <= hi_i;
      r_step     <= step_i;
      r_start    <= start_i;
      r_dat      <= start_i;
      r_dir_down <= 1'b0;
    end else if (run_i) begin
      r_dat      <= w_dat_next;
      r_dir_down <= w_dir_next;
    end
  end

  assign dat_o = r_dat;

endmodule

// File: rtl/adc_pattern_gen.sv
// NCH-channel ADC test-pattern source with a shared Galois LFSR and a
// jittered periodic trigger whose rising edges are counted.
module adc_pattern_gen
  import adc_pattern_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 14,
  parameter int TW  = 32,
  parameter int JW  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              run_i,
  input  logic [NCH*2-1:0]  mode_i,
  input  logic [NCH*DW-1:0] lo_i,
  input  logic [NCH*DW-1:0] hi_i,
  input  logic [NCH*DW-1:0] step_i,
  input  logic [NCH*DW-1:0] start_i,
  input  logic [TW-1:0]     trig_per_i,
  input  logic [JW-1:0]     trig_len_i,
  input  logic [JW-1:0]     jit_msk_i,
  output logic [NCH*DW-1:0] dat_o,
  output logic              dat_vld_o,
  output logic              trig_o,
  output logic [31:0]       trig_cnt_o
);

  localparam logic [TW:0] P_ONE = (TW+1)'(1);

  logic [15:0]   r_lfsr;
  logic [TW-1:0] r_per;
  logic [JW-1:0] r_len;
  logic [JW-1:0] r_msk;
  logic [TW:0]   r_cnt;
  logic [TW:0]   r_pcur;
  logic          r_trig;
  logic [31:0]   r_trig_cnt;
  logic          r_vld;

  logic [15:0]   w_lfsr_next;
  logic [TW:0]   w_jit;
  logic [TW:0]   w_per_eff;
  logic [TW:0]   w_len1;
  logic [TW:0]   w_len_eff;
  logic [TW:0]   w_cnt_next;
  logic          w_trig_next;
  logic          w_trig_en;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DW-1:0] w_noise;
      assign w_noise = DW'(rotl16(r_lfsr, 3 * gi));

      adc_pattern_ch #(.DW(DW)) u_ch (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load_i),
        .run_i   (run_i),
        .mode_i  (mode_i[gi*2 +: 2]),
        .lo_i    (lo_i[gi*DW +: DW]),
        .hi_i    (hi_i[gi*DW +: DW]),
        .step_i  (step_i[gi*DW +: DW]),
        .start_i (start_i[gi*DW +: DW]),
        .noise_i (w_noise),
        .dat_o   (dat_o[gi*DW +: DW])
      );
    end
  endgenerate

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign w_trig_en   = (r_per != '0);

  // The period is only resampled at count 0; mid-period it comes from r_pcur.
  always_comb begin
    w_jit     = (TW+1)'(r_lfsr[JW-1:0] & r_msk);
    w_per_eff = (r_cnt == '0) ? ({1'b0, r_per} + w_jit) : r_pcur;
    w_len1    = (r_len == '0) ? P_ONE : (TW+1)'(r_len);
    if (w_per_eff <= P_ONE)
      w_len_eff = P_ONE;
    else if (w_len1 > w_per_eff - P_ONE)
      w_len_eff = w_per_eff - P_ONE;
    else
      w_len_eff = w_len1;
    w_cnt_next  = (r_cnt >= w_per_eff - P_ONE) ? '0 : r_cnt + P_ONE;
    w_trig_next = w_trig_en && (r_cnt < w_len_eff);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr     <= LFSR_SEED;
      r_per      <= '0;
      r_len      <= '0;
      r_msk      <= '0;
      r_cnt      <= '0;
      r_pcur     <= '0;
      r_trig     <= 1'b0;
      r_trig_cnt <= '0;
      r_vld      <= 1'b0;
    end else begin
      r_vld <= run_i;
      if (load_i) begin
        r_per      <= trig_per_i;
        r_len      <= trig_len_i;
        r_msk      <= jit_msk_i;
        r_cnt      <= '0;
        r_pcur     <= '0;
        r_trig     <= 1'b0;
        r_trig_cnt <= '0;
      end else if (run_i) begin
        r_lfsr <= w_lfsr_next;
        if (w_trig_en) begin
          r_cnt  <= w_cnt_next;
          r_pcur <= w_per_eff;
        end
        r_trig <= w_trig_next;
        if (w_trig_next && !r_trig)
          r_trig_cnt <= r_trig_cnt + 32'd1;
      end else begin
        r_trig <= 1'b0;
      end
    end
  end

  assign dat_vld_o  = r_vld;
  assign trig_o     = r_trig;
  assign trig_cnt_o = r_trig_cnt;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Directed bench for adc_pattern_gen: waveforms, trigger timing, jitter and control paths.
module tb_adc_pattern_gen;
  import adc_pattern_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 14;
  localparam int TW  = 32;
  localparam int JW  = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              load_i;
  logic              run_i;
  logic [NCH*2-1:0]  mode_i;
  logic [NCH*DW-1:0] lo_i;
  logic [NCH*DW-1:0] hi_i;
  logic [NCH*DW-1:0] step_i;
  logic [NCH*DW-1:0] start_i;
  logic [TW-1:0]     trig_per_i;
  logic [JW-1:0]     trig_len_i;
  logic [JW-1:0]     jit_msk_i;
  logic [NCH*DW-1:0] dat_o;
  logic              dat_vld_o;
  logic              trig_o;
  logic [31:0]       trig_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  adc_pattern_gen #(.NCH(NCH), .DW(DW), .TW(TW), .JW(JW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_i),
    .run_i      (run_i),
    .mode_i     (mode_i),
    .lo_i       (lo_i),
    .hi_i       (hi_i),
    .step_i     (step_i),
    .start_i    (start_i),
    .trig_per_i (trig_per_i),
    .trig_len_i (trig_len_i),
    .jit_msk_i  (jit_msk_i),
    .dat_o      (dat_o),
    .dat_vld_o  (dat_vld_o),
    .trig_o     (trig_o),
    .trig_cnt_o (trig_cnt_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int ch(int c);
    logic signed [DW-1:0] v;
    v = dat_o[c*DW +: DW];
    return int'(v);
  endfunction

  task automatic cfg_ch(int c, pat_mode_t m, int lo, int hi, int st, int start);
    mode_i[c*2 +: 2]    = m;
    lo_i[c*DW +: DW]    = lo[DW-1:0];
    hi_i[c*DW +: DW]    = hi[DW-1:0];
    step_i[c*DW +: DW]  = st[DW-1:0];
    start_i[c*DW +: DW] = start[DW-1:0];
  endtask

  task automatic cfg_trig(int per, int len, int msk);
    trig_per_i = per;
    trig_len_i = len[JW-1:0];
    jit_msk_i  = msk[JW-1:0];
  endtask

  task automatic do_reset();
    rst_i = 1'b1; run_i = 1'b0; load_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic do_load();
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    cfg_ch(0, PAT_RAMP, -10, 10, 1, 5);
    cfg_trig(3, 1, 0);
    rst_i = 1'b1; run_i = 1'b1; load_i = 1'b0;
    tick();
    n_cmp++; if (dat_o !== '0) begin n_err++; $display("FAIL reset_dat: got %h want 0", dat_o); end
    n_cmp++; if (dat_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", dat_vld_o); end
    n_cmp++; if (trig_o !== 1'b0) begin n_err++; $display("FAIL reset_trig: got %b want 0", trig_o); end
    n_cmp++; if (trig_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_trig_cnt: got %0d want 0", trig_cnt_o); end
    rst_i = 1'b0; run_i = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_ramp();
    do_reset();
    cfg_ch(0, PAT_RAMP, -1000, 1000, 1, -500);
    cfg_ch(1, PAT_CONST, 0, 200, 5, 123);
    cfg_trig(0, 1, 0);
    do_load();
    n_cmp++; if (ch(0) !== -500) begin n_err++; $display("FAIL ramp_load: got %0d want -500", ch(0)); end
    run_i = 1'b1;
    tick();
    n_cmp++; if (ch(0) !== -499) begin n_err++; $display("FAIL ramp_edge1: got %0d want -499", ch(0)); end
    n_cmp++; if (dat_vld_o !== 1'b1) begin n_err++; $display("FAIL ramp_vld: got %b want 1", dat_vld_o); end
    n_cmp++; if (ch(1) !== 123) begin n_err++; $display("FAIL const_ch1: got %0d want 123", ch(1)); end
    for (int i = 2; i <= 1500; i++) tick();
    n_cmp++; if (ch(0) !== 1000) begin n_err++; $display("FAIL ramp_edge1500: got %0d want 1000", ch(0)); end
    tick();
    n_cmp++; if (ch(0) !== -1000) begin n_err++; $display("FAIL ramp_edge1501: got %0d want -1000", ch(0)); end
    run_i = 1'b0;
    $display("test_ramp done");
  endtask

  task automatic test_tri();
    int exp_seq[8] = '{4, 8, 10, 6, 2, 0, 4, 8};
    do_reset();
    cfg_ch(0, PAT_TRI, 0, 10, 4, 0);
    do_load();
    run_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (ch(0) !== exp_seq[i]) begin
        n_err++; $display("FAIL tri_step%0d: got %0d want %0d", i, ch(0), exp_seq[i]);
      end
    end
    run_i = 1'b0;
    $display("test_tri done");
  endtask

  task automatic test_trigger();
    int errs = 0;
    logic exp_t;
    do_reset();
    cfg_trig(250, 3, 0);
    do_load();
    run_i = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      exp_t = (((i - 1) % 250) < 3);
      if (trig_o !== exp_t) errs++;
    end
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL trig_shape: got %0d bad cycles want 0", errs); end
    n_cmp++; if (trig_cnt_o !== 32'd4) begin n_err++; $display("FAIL trig_count: got %0d want 4", trig_cnt_o); end
    tick();
    run_i = 1'b0;
    tick();
    n_cmp++; if (trig_o !== 1'b0) begin n_err++; $display("FAIL trig_run_low: got %b want 0", trig_o); end
    $display("test_trigger done");
  endtask

  task automatic test_jitter();
    int  edges = 0, last = 0, bad = 0, distinct = 0, p;
    bit  seen[128];
    logic prev = 1'b0;
    do_reset();
    cfg_trig(100, 2, 8'h0F);
    do_load();
    run_i = 1'b1;
    for (int i = 1; i <= 64 * 120 && edges < 65; i++) begin
      tick();
      if (trig_o === 1'b1 && prev === 1'b0) begin
        if (edges > 0) begin
          p = i - last;
          if (p < 100 || p > 115) bad++;
          else if (!seen[p]) begin seen[p] = 1'b1; distinct++; end
        end
        last = i;
        edges++;
      end
      prev = trig_o;
    end
    run_i = 1'b0;
    n_cmp++; if (edges !== 65) begin n_err++; $display("FAIL jit_edges: got %0d want 65", edges); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL jit_range: got %0d out-of-range periods want 0", bad); end
    n_cmp++; if (distinct < 8) begin n_err++; $display("FAIL jit_distinct: got %0d want >=8", distinct); end
    n_cmp++; if (trig_cnt_o !== 32'd65) begin n_err++; $display("FAIL jit_trig_cnt: got %0d want 65", trig_cnt_o); end
    $display("test_jitter done");
  endtask

  task automatic test_edge_cases();
    int errs = 0, highs = 0;
    logic at50 = 1'b1;
    do_reset();
    cfg_trig(1, 0, 0);
    do_load();
    run_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (trig_o !== 1'b1) errs++;
    end
    run_i = 1'b0;
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL per1_high: got %0d low cycles want 0", errs); end
    n_cmp++; if (trig_cnt_o !== 32'd1) begin n_err++; $display("FAIL per1_cnt: got %0d want 1", trig_cnt_o); end

    do_reset();
    cfg_trig(50, 200, 0);
    do_load();
    run_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (trig_o === 1'b1) highs++;
      if (i == 50) at50 = trig_o;
    end
    run_i = 1'b0;
    n_cmp++; if (highs !== 98) begin n_err++; $display("FAIL len_clamp_highs: got %0d want 98", highs); end
    n_cmp++; if (at50 !== 1'b0) begin n_err++; $display("FAIL len_clamp_gap: got %b want 0", at50); end
    n_cmp++; if (trig_cnt_o !== 32'd2) begin n_err++; $display("FAIL len_clamp_cnt: got %0d want 2", trig_cnt_o); end

    do_reset();
    cfg_trig(0, 1, 0);
    cfg_ch(0, PAT_RAMP, 0, 100, 0, 77);
    cfg_ch(1, PAT_RAMP, 50, -50, 3, 0);
    do_load();
    run_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    run_i = 1'b0;
    n_cmp++; if (ch(0) !== 77) begin n_err++; $display("FAIL step0_hold: got %0d want 77", ch(0)); end
    n_cmp++; if (ch(1) !== 50) begin n_err++; $display("FAIL lo_gt_hi: got %0d want 50", ch(1)); end

    do_reset();
    cfg_ch(0, PAT_NOISE, -8192, 8191, 0, 0);
    cfg_ch(2, PAT_NOISE, -5, 5, 0, 0);
    do_load();
    run_i = 1'b1;
    tick();
    n_cmp++; if (ch(0) !== -4895) begin n_err++; $display("FAIL noise_edge1: got %0d want -4895", ch(0)); end
    n_cmp++; if (ch(2) !== -5) begin n_err++; $display("FAIL noise_clip: got %0d want -5", ch(2)); end
    tick();
    n_cmp++; if (ch(0) !== -7568) begin n_err++; $display("FAIL noise_edge2: got %0d want -7568", ch(0)); end
    run_i = 1'b0;
    $display("test_edge_cases done");
  endtask

  task automatic test_control();
    do_reset();
    cfg_ch(0, PAT_RAMP, -1000, 1000, 1, -500);
    cfg_trig(5, 1, 0);
    load_i = 1'b1; run_i = 1'b1;
    tick();
    load_i = 1'b0;
    n_cmp++; if (ch(0) !== -500) begin n_err++; $display("FAIL load_run_no_adv: got %0d want -500", ch(0)); end
    tick();
    tick();
    n_cmp++; if (ch(0) !== -498) begin n_err++; $display("FAIL ctl_adv2: got %0d want -498", ch(0)); end
    n_cmp++; if (trig_cnt_o !== 32'd1) begin n_err++; $display("FAIL ctl_trig_cnt: got %0d want 1", trig_cnt_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_cmp++; if (ch(0) !== 0) begin n_err++; $display("FAIL rst_mid_dat: got %0d want 0", ch(0)); end
    n_cmp++; if (trig_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d want 0", trig_cnt_o); end
    n_cmp++; if (dat_vld_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_vld: got %b want 0", dat_vld_o); end
    run_i = 1'b0;
    do_load();
    run_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    run_i = 1'b0;
    tick();
    tick();
    n_cmp++; if (ch(0) !== -495) begin n_err++; $display("FAIL run_low_hold: got %0d want -495", ch(0)); end
    n_cmp++; if (dat_vld_o !== 1'b0) begin n_err++; $display("FAIL run_low_vld: got %b want 0", dat_vld_o); end
    n_cmp++; if (trig_o !== 1'b0) begin n_err++; $display("FAIL run_low_trig: got %b want 0", trig_o); end
    $display("test_control done");
  endtask

  initial begin
    rst_i = 1'b1; load_i = 1'b0; run_i = 1'b0;
    mode_i = '0; lo_i = '0; hi_i = '0; step_i = '0; start_i = '0;
    trig_per_i = '0; trig_len_i = '0; jit_msk_i = '0;
    test_reset();
    test_ramp();
    test_tri();
    test_trigger();
    test_jitter();
    test_edge_cases();
    test_control();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
